// File: rtl/ecc_point_add_ctrl_pkg.sv
// ecc_ctrl_pkg: shared types for the point-add sequencer (GF op codes, operand sources, FSM states, microop record)
package ecc_ctrl_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} gf_op_e;
  typedef enum logic [2:0] {SRC_X1, SRC_Y1, SRC_X2, SRC_Y2, SRC_T0, SRC_T1, SRC_T2} src_e;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH, S_ERR} state_e;
  typedef struct packed {
    gf_op_e op;
    src_e   src_a;
    src_e   src_b;
    src_e   dst;
  } uop_t;
  localparam logic [3:0] LAST_STEP = 4'd8;
endpackage

// File: rtl/ecc_point_add_ctrl_rom.sv
// ecc_pa_rom: step -> microop lookup for the nine-operation affine point-add program
// Ports: i_step (4-bit step index), o_uop (op, srcA, srcB, dst); steps past 8 give ADD T0 = T0, T0
module ecc_pa_rom
  import ecc_ctrl_pkg::*;
(
  input  logic [3:0] i_step,
  output uop_t       o_uop
);
  always_comb begin
    o_uop = '{OP_ADD, SRC_T0, SRC_T0, SRC_T0};
    case (i_step)
      4'd0: o_uop = '{OP_SUB, SRC_Y2, SRC_Y1, SRC_T0};
      4'd1: o_uop = '{OP_SUB, SRC_X2, SRC_X1, SRC_T1};
      4'd2: o_uop = '{OP_DIV, SRC_T0, SRC_T1, SRC_T0};
      4'd3: o_uop = '{OP_MUL, SRC_T0, SRC_T0, SRC_T1};
      4'd4: o_uop = '{OP_SUB, SRC_T1, SRC_X1, SRC_T1};
      4'd5: o_uop = '{OP_SUB, SRC_T1, SRC_X2, SRC_T1};
      4'd6: o_uop = '{OP_SUB, SRC_X1, SRC_T1, SRC_T2};
      4'd7: o_uop = '{OP_MUL, SRC_T0, SRC_T2, SRC_T2};
      4'd8: o_uop = '{OP_SUB, SRC_T2, SRC_Y1, SRC_T2};
      default: o_uop = '{OP_ADD, SRC_T0, SRC_T0, SRC_T0};
    endcase
  end
endmodule

// File: rtl/ecc_point_add_ctrl.sv
// ecc_point_add_ctrl: sequences R = P1 + P2 (affine) through a shared GF unit via go/done handshake
// Ports: i_start/i_x1/i_y1/i_x2/i_y2/i_prime request; o_busy/o_done/o_err/o_x3/o_y3 status and result;
//        o_gf_in_0/o_gf_in_1/o_gf_prime/o_gf_op/o_gf_go drive the GF unit, i_gf_result/i_gf_done return from it
module ecc_point_add_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_y1,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_y2,
  input  logic [WIDTH-1:0] i_prime,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_x3,
  output logic [WIDTH-1:0] o_y3,
  output logic [WIDTH-1:0] o_gf_in_0,
  output logic [WIDTH-1:0] o_gf_in_1,
  output logic [WIDTH-1:0] o_gf_prime,
  output logic [1:0]       o_gf_op,
  output logic             o_gf_go,
  input  logic [WIDTH-1:0] i_gf_result,
  input  logic             i_gf_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e                  r_state, w_next;
  logic [WIDTH-1:0]        r_x1, r_y1, r_x2, r_y2, r_p, r_t0, r_t1, r_t2;
  logic [3:0]              r_step;
  logic [TW-1:0]           r_tmo;
  uop_t                    w_uop;
  logic [7:0][WIDTH-1:0]   w_src;
  logic                    w_idle;
  ecc_pa_rom u_rom (.i_step(r_step), .o_uop(w_uop));
  // packed index follows src_e encoding; slot 7 is unused and reads zero
  assign w_src  = {WIDTH'(0), r_t2, r_t1, r_t0, r_y2, r_x2, r_y1, r_x1};
  assign w_idle = r_state == S_IDLE;
  assign o_gf_prime = r_p;
  always_comb begin
    w_next    = r_state;
    o_busy    = !w_idle;
    o_done    = r_state == S_FINISH || r_state == S_ERR;
    o_err     = r_state == S_ERR;
    o_gf_go   = r_state == S_ISSUE;
    o_gf_op   = w_idle ? 2'd0 : w_uop.op;
    o_gf_in_0 = w_idle ? '0 : w_src[w_uop.src_a];
    o_gf_in_1 = w_idle ? '0 : w_src[w_uop.src_b];
    case (r_state)
      S_IDLE:  w_next = i_start ? (i_x1 == i_x2 ? S_ERR : S_ISSUE) : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = i_gf_done ? (r_step == LAST_STEP ? S_FINISH : S_ISSUE)
                                  : (r_tmo == TW'(TIMEOUT - 1) ? S_ERR : S_WAIT);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      {r_x1, r_y1, r_x2, r_y2, r_p, r_t0, r_t1, r_t2} <= '0;
      r_step  <= '0;
      r_tmo   <= '0;
      o_x3    <= '0;
      o_y3    <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && i_start) begin
        {r_x1, r_y1, r_x2, r_y2, r_p} <= {i_x1, i_y1, i_x2, i_y2, i_prime};
        r_step <= '0;
      end
      if (r_state == S_ISSUE) r_tmo <= '0;
      if (r_state == S_WAIT) r_tmo <= r_tmo + TW'(1);
      if (r_state == S_WAIT && i_gf_done) begin
        if (w_uop.dst == SRC_T0) r_t0 <= i_gf_result;
        if (w_uop.dst == SRC_T1) r_t1 <= i_gf_result;
        if (w_uop.dst == SRC_T2) r_t2 <= i_gf_result;
        r_step <= r_step + 4'd1;
      end
      if (r_state == S_FINISH) begin
        o_x3 <= r_t1;
        o_y3 <= r_t2;
      end
    end
  end
endmodule

// File: doc/ecc_point_add_ctrl.md
# ecc_point_add_ctrl

Sequencer that computes the elliptic-curve point sum R = P1 + P2 (affine, P1 ≠ ±P2) over GF(p). It issues the nine-operation microprogram through the shared GF arithmetic unit (add/sub/mult/div, op codes 0/1/2/3) using the unit's go/done handshake. It sits between the top-level ECC controller and the GF arithmetic unit and owns that unit while busy. The block does not depend on the operand representation: it issues op codes only, and arithmetic correctness belongs to the GF unit.

## Interface
- WIDTH, 32, field element width
- TIMEOUT, 1023, maximum cycles to wait for one GF operation before aborting
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle request; sampled only in IDLE
- i_x1, i_y1, i_x2, i_y2  in  WIDTH each  input points, latched on accepted start
- i_prime  in  WIDTH  field modulus, latched on accepted start
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done; 1 = x1==x2 or timeout
- o_x3, o_y3  out  WIDTH  result; held until the next completion
- o_gf_in_0, o_gf_in_1  out  WIDTH  GF unit operands
- o_gf_prime  out  WIDTH  latched modulus
- o_gf_op  out  2  GF op select
- o_gf_go  out  1  GF start (the unit's done_from_control); one-cycle pulse
- i_gf_result  in  WIDTH  GF result, valid while i_gf_done=1
- i_gf_done  in  1  GF completion pulse (the unit's done_to_control)

## Operation
- Registers: latched X1, Y1, X2, Y2, P; temporaries T0, T1, T2; 4-bit step counter; timeout counter (10 bits, wide enough for TIMEOUT); state.
- Microprogram, step: op dst = srcA, srcB:
  - 0: SUB T0 = Y2, Y1
  - 1: SUB T1 = X2, X1
  - 2: DIV T0 = T0, T1 (lambda)
  - 3: MUL T1 = T0, T0
  - 4: SUB T1 = T1, X1
  - 5: SUB T1 = T1, X2 (x3)
  - 6: SUB T2 = X1, T1
  - 7: MUL T2 = T0, T2
  - 8: SUB T2 = T2, Y1 (y3)
- FSM states:
  - IDLE: on i_start, latch the inputs and clear step. Go to ERR if i_x1==i_x2; otherwise go to ISSUE.
  - ISSUE: o_gf_go=1 for exactly one cycle. o_gf_op and the operands come from the current step. Clear the timeout counter. Go to WAIT.
  - WAIT: operands and op are held stable and o_gf_go=0. When i_gf_done=1, write i_gf_result to dst. Then go to FINISH if step==8; otherwise increment step and go to ISSUE. If the timeout counter reaches TIMEOUT without i_gf_done, go to ERR.
  - FINISH: o_done=1, o_err=0. Load o_x3 from T1 and o_y3 from T2. Go to IDLE.
  - ERR: o_done=1 and o_err=1 for one cycle. o_x3/o_y3 are left unchanged. Go to IDLE.
- i_start while not in IDLE is ignored, with no queuing.
- i_gf_done outside WAIT is ignored.
- Operand muxes drive zero in IDLE.

## Timing
- Reset values: every output is 0, state is IDLE, and all registers are 0. Reset mid-operation aborts immediately with no o_done; the GF unit shares i_rst.
- Start sampled at cycle s → ISSUE for step 0 at s+1 (o_busy=1 from s+1).
- GF latency L = cycles from the go cycle to the i_gf_done cycle (L ≥ 1). One step occupies L+1 cycles, so the next go never coincides with a done.
- Normal completion: o_done in cycle s+1+9(L+1); o_x3/o_y3 valid from the next cycle.
- x1==x2: o_done and o_err in cycle s+1; no go is issued.
- Timeout: ERR follows TIMEOUT cycles of WAIT without i_gf_done.
- o_busy falls in the cycle after o_done. A new start is accepted in that same cycle (IDLE).

## Structure
- Package ecc_ctrl_pkg holds:
  - the GF op codes (ADD=0, SUB=1, MUL=2, DIV=3);
  - operand source codes (X1, Y1, X2, Y2, T0, T1, T2);
  - the FSM state encoding;
  - the microop record {op, srcA, srcB, dst}.
- One sub-module, ecc_pa_rom: a combinational step→microop lookup (9 entries; out-of-range steps return ADD T0 = T0, T0).

## Test plan
- Behavioral GF model with plain modular arithmetic and L=2, p=23, P1=(3,10), P2=(9,7) → o_done at s+28 with o_err=0, o_x3=17, o_y3=20; exactly nine go pulses carrying op sequence 1,1,3,2,1,1,1,2,1.
- Same inputs with model L=34 (mult-like) → o_done at s+316 and the same result; operands stable across every WAIT.
- x1==x2 (P1=(3,10), P2=(3,13)) → o_done and o_err at s+1, no go pulses, and o_x3/o_y3 keep their previous values.
- Model never asserts done on step 2, TIMEOUT=15 → o_err pulse 15 WAIT cycles after the third go; o_busy drops next.
- i_start asserted during busy, then i_rst pulsed low mid-WAIT → start ignored; reset forces all outputs to 0 and IDLE, and there is no o_done.
- Two back-to-back starts, the second in the cycle after o_done → both accepted; the second result replaces the first.
